// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC-select and branch-condition codes, opcodes,
// IR field positions and the fetch-unit state encoding.
package cpu_pkg;

    localparam logic [1:0] PS_HOLD      = 2'd0;
    localparam logic [1:0] PS_INCREMENT = 2'd1;
    localparam logic [1:0] PS_REL_JUMP  = 2'd2;
    localparam logic [1:0] PS_ABS_JUMP  = 2'd3;

    localparam logic [1:0] BC_ZERO     = 2'd0;
    localparam logic [1:0] BC_NZERO    = 2'd1;
    localparam logic [1:0] BC_NEGATIVE = 2'd2;
    localparam logic [1:0] BC_ALWAYS   = 2'd3;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_LI   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_BNE  = 4'hA;
    localparam logic [3:0] OP_BLT  = 4'hB;
    localparam logic [3:0] OP_J    = 4'hC;
    localparam logic [3:0] OP_JR   = 4'hD;
    localparam logic [3:0] OP_JAL  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 8;
    localparam int unsigned RS_MSB  = 7;
    localparam int unsigned RS_LSB  = 4;
    localparam int unsigned RT_MSB  = 3;
    localparam int unsigned RT_LSB  = 0;
    localparam int unsigned IMM_MSB = 7;
    localparam int unsigned IMM_LSB = 0;

    typedef enum logic [1:0] {
        FS_RUN      = 2'd0,
        FS_WAIT_MEM = 2'd1,
        FS_HALT     = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/branch_eval.sv
// Branch condition evaluator. The NEGATIVE condition is honoured only when
// PC_FETCH_NEG_BRANCH_EN is defined; otherwise it is never taken.
module branch_eval
    import cpu_pkg::*;
(
    input  logic [1:0] bc,
    input  logic       zero,
    input  logic       negative,
    output logic       taken
);

`ifndef PC_FETCH_NEG_BRANCH_EN
    logic unused_negative;
    assign unused_negative = negative;
`endif

    always_comb begin
        taken = 1'b0;
        case (bc)
            BC_ZERO:     taken = zero;
            BC_NZERO:    taken = ~zero;
`ifdef PC_FETCH_NEG_BRANCH_EN
            BC_NEGATIVE: taken = negative;
`else
            BC_NEGATIVE: taken = 1'b0;
`endif
            BC_ALWAYS:   taken = 1'b1;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter / instruction register owner with req/ready instruction fetch.
// Optional macro PC_FETCH_NEG_BRANCH_EN enables the NEGATIVE branch condition.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned           PC_WIDTH    = 8,
    parameter int unsigned           INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             ps,
    input  logic [1:0]             bc,
    input  logic                   il,
    input  logic                   eoe,
    input  logic                   zero,
    input  logic                   negative,
    input  logic [PC_WIDTH-1:0]    abs_target,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   imem_ready,
    output logic [3:0]             opcode,
    output logic [3:0]             rd,
    output logic [3:0]             rs,
    output logic [3:0]             rt,
    output logic [7:0]             imm,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   stall,
    output logic                   halted
);

    fetch_state_e           state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic [PC_WIDTH-1:0]    pc_next;
    logic [PC_WIDTH-1:0]    rel_off;
    logic                   taken;

    branch_eval u_branch_eval (
        .bc       (bc),
        .zero     (zero),
        .negative (negative),
        .taken    (taken)
    );

    assign rel_off = PC_WIDTH'($signed(ir_q[IMM_MSB:IMM_LSB]));

    always_comb begin
        pc_next = pc_q;
        case (ps)
            PS_HOLD:      pc_next = pc_q;
            PS_INCREMENT: pc_next = pc_q + PC_WIDTH'(1);
            PS_REL_JUMP:  pc_next = taken ? (pc_q + rel_off) : (pc_q + PC_WIDTH'(1));
            PS_ABS_JUMP:  pc_next = abs_target;
            default:      pc_next = pc_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            FS_RUN: begin
                if (eoe) begin
                    state_d = FS_HALT;
                end else if (il && !imem_ready) begin
                    // PC is held on a missed fetch so imem_addr stays stable through WAIT_MEM.
                    state_d = FS_WAIT_MEM;
                end else begin
                    if (il) ir_d = imem_rdata;
                    pc_d = pc_next;
                end
            end
            FS_WAIT_MEM: begin
                if (eoe) begin
                    state_d = FS_HALT;
                end else if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = FS_RUN;
                end
            end
            FS_HALT: state_d = FS_HALT;
            default: state_d = FS_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FS_RUN;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign imem_req  = ((state_q == FS_RUN) && il) || (state_q == FS_WAIT_MEM);
    assign imem_addr = pc_q;
    assign stall     = (state_q == FS_WAIT_MEM);
    assign halted    = (state_q == FS_HALT);
    assign pc        = pc_q;
    assign opcode    = ir_q[OPC_MSB:OPC_LSB];
    assign rd        = ir_q[RD_MSB:RD_LSB];
    assign rs        = ir_q[RS_MSB:RS_LSB];
    assign rt        = ir_q[RT_MSB:RT_LSB];
    assign imm       = ir_q[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: driver queues hand-computed post-edge
// state, a negedge monitor pops and compares against the DUT outputs.
module tb_pc_fetch_unit;

    localparam logic [1:0] H = 2'd0, I = 2'd1, R = 2'd2, A = 2'd3;
    localparam logic [1:0] BZ = 2'd0, BNZ = 2'd1, BN = 2'd2, BAL = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  ps = '0, bc = '0;
    logic        il = 1'b0, eoe = 1'b0, zero = 1'b0, negative = 1'b0;
    logic [7:0]  abs_target = '0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        imem_ready = 1'b0;
    logic [3:0]  opcode, rd, rs, rt;
    logic [7:0]  imm, pc;
    logic        stall, halted;

    pc_fetch_unit #(.PC_WIDTH(8), .INSTR_WIDTH(16), .RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset), .ps(ps), .bc(bc), .il(il), .eoe(eoe),
        .zero(zero), .negative(negative), .abs_target(abs_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready), .opcode(opcode), .rd(rd), .rs(rs), .rt(rt),
        .imm(imm), .pc(pc), .stall(stall), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [7:0]  pc;
        logic [15:0] ir;
        logic        stall;
        logic        halted;
        logic        req;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.name, " pc"},     {8'h00, pc},              {8'h00, e.pc});
            chk({e.name, " addr"},   {8'h00, imem_addr},       {8'h00, e.pc});
            chk({e.name, " fields"}, {opcode, rd, rs, rt},     e.ir);
            chk({e.name, " imm"},    {8'h00, imm},             {8'h00, e.ir[7:0]});
            chk({e.name, " stall"},  {15'h0, stall},           {15'h0, e.stall});
            chk({e.name, " halted"}, {15'h0, halted},          {15'h0, e.halted});
            chk({e.name, " req"},    {15'h0, imem_req},        {15'h0, e.req});
        end
    end

    task automatic step(input string nm, input logic rst_v, input logic [1:0] ps_v,
                        input logic [1:0] bc_v, input logic il_v, input logic eoe_v,
                        input logic z_v, input logic n_v, input logic [7:0] abs_v,
                        input logic [15:0] rdata_v, input logic rdy_v,
                        input logic [7:0] e_pc, input logic [15:0] e_ir,
                        input logic e_stall, input logic e_halt, input logic e_req);
        exp_t e;
        @(negedge clk);
        #1;
        reset = rst_v; ps = ps_v; bc = bc_v; il = il_v; eoe = eoe_v;
        zero = z_v; negative = n_v; abs_target = abs_v;
        imem_rdata = rdata_v; imem_ready = rdy_v;
        @(posedge clk);
        e.name = nm; e.pc = e_pc; e.ir = e_ir;
        e.stall = e_stall; e.halted = e_halt; e.req = e_req;
        q.push_back(e);
    endtask

    logic [7:0] p_neg;

    initial begin
`ifdef PC_FETCH_NEG_BRANCH_EN
        p_neg = 8'h24;
`else
        p_neg = 8'h21;
`endif
        //    name        rst ps bc  il eoe z n abs    rdata    rdy   pc     ir      stl hlt req
        step("reset",     1, H, BZ, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 0, 0, 0);
        step("fetch0",    0, H, BZ, 1, 0, 0, 0, 8'h00, 16'h8A05, 1, 8'h00, 16'h8A05, 0, 0, 1);
        step("miss1",     0, I, BZ, 1, 0, 0, 0, 8'h00, 16'h1234, 0, 8'h00, 16'h8A05, 1, 0, 1);
        step("wait2",     0, I, BZ, 1, 0, 0, 0, 8'h00, 16'h1234, 0, 8'h00, 16'h8A05, 1, 0, 1);
        step("wait3",     0, I, BZ, 1, 0, 0, 0, 8'h00, 16'h1234, 0, 8'h00, 16'h8A05, 1, 0, 1);
        step("ready",     0, I, BZ, 0, 0, 0, 0, 8'h00, 16'h10FE, 1, 8'h00, 16'h10FE, 0, 0, 0);
        step("abs10",     0, A, BZ, 0, 0, 0, 0, 8'h10, 16'h0000, 0, 8'h10, 16'h10FE, 0, 0, 0);
        step("relz_t",    0, R, BZ, 0, 0, 1, 0, 8'h00, 16'h0000, 0, 8'h0E, 16'h10FE, 0, 0, 0);
        step("abs10b",    0, A, BZ, 0, 0, 0, 0, 8'h10, 16'h0000, 0, 8'h10, 16'h10FE, 0, 0, 0);
        step("relz_nt",   0, R, BZ, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h11, 16'h10FE, 0, 0, 0);
        step("relnz_t",   0, R, BNZ,0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h0F, 16'h10FE, 0, 0, 0);
        step("relal",     0, R, BAL,0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h0D, 16'h10FE, 0, 0, 0);
        step("relnz_nt",  0, R, BNZ,0, 0, 1, 0, 8'h00, 16'h0000, 0, 8'h0E, 16'h10FE, 0, 0, 0);
        step("absff",     0, A, BZ, 0, 0, 0, 0, 8'hFF, 16'h0000, 0, 8'hFF, 16'h10FE, 0, 0, 0);
        step("wrap",      0, I, BZ, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h10FE, 0, 0, 0);
        step("fetch80",   0, A, BZ, 1, 0, 0, 0, 8'h40, 16'h0080, 1, 8'h40, 16'h0080, 0, 0, 1);
        step("rel80",     0, R, BAL,0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'hC0, 16'h0080, 0, 0, 0);
        step("fetch04",   0, A, BZ, 1, 0, 0, 0, 8'h20, 16'h0004, 1, 8'h20, 16'h0004, 0, 0, 1);
        step("relneg",    0, R, BN, 0, 0, 0, 1, 8'h00, 16'h0000, 0, p_neg, 16'h0004, 0, 0, 0);
        step("miss_h",    0, H, BZ, 1, 0, 0, 0, 8'h00, 16'h5555, 0, p_neg, 16'h0004, 1, 0, 1);
        step("eoe_wait",  0, H, BZ, 1, 1, 0, 0, 8'h00, 16'hFFFF, 1, p_neg, 16'h0004, 0, 1, 0);
        step("halt_inc",  0, I, BZ, 1, 0, 0, 0, 8'h00, 16'hFFFF, 1, p_neg, 16'h0004, 0, 1, 0);
        step("halt_abs",  0, A, BZ, 1, 1, 0, 0, 8'h55, 16'hFFFF, 1, p_neg, 16'h0004, 0, 1, 0);
        step("reset2",    1, H, BZ, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 0, 0, 0);
        step("eoe_run",   0, I, BZ, 1, 1, 0, 0, 8'h00, 16'hBEEF, 1, 8'h00, 16'h0000, 0, 1, 0);
        step("reset3",    1, H, BZ, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 0, 0, 0);
        step("post_rst",  0, I, BZ, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h01, 16'h0000, 0, 0, 0);
        step("miss_r",    0, H, BZ, 1, 0, 0, 0, 8'h00, 16'h7777, 0, 8'h01, 16'h0000, 1, 0, 1);
        step("rst_mid",   1, H, BZ, 0, 0, 0, 0, 8'h00, 16'h1111, 1, 8'h00, 16'h0000, 0, 0, 0);

        @(negedge clk);
        #2;
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
